// File: rtl/render_pkg.sv
// Shared render-pipeline definitions: fixed-point defaults, background brightness,
// the resolver state enum and the framebuffer address type.
package render_pkg;

    localparam int unsigned TOTAL_PREC_DEF = 27;
    localparam int unsigned FRAC_BITS_DEF  = 22;     // 1.0 = 4194304
    localparam logic [7:0]  BG_BRI_DEF     = 8'd0;

    typedef logic [19:0] fb_addr_t;

    typedef enum logic {
        IDLE,
        ACCUM
    } resolve_state_t;

endpackage

// File: rtl/hit_resolve_if.sv
// Bus between the render pipeline output, the hit resolver and the framebuffer port.
//   Beat side (master drives): in_valid, fb_addr, last_tri, last_pix, hit, t, bri
//   Result side (slave drives): fb_we, fb_waddr, fb_wdata, frame_done, busy,
//                               pix_count, hit_count, addr_err
interface hit_resolve_if #(
    parameter int unsigned TOTAL_PREC = render_pkg::TOTAL_PREC_DEF
) ();
    import render_pkg::*;

    logic                         in_valid;
    fb_addr_t                     fb_addr;
    logic                         last_tri;
    logic                         last_pix;
    logic                         hit;
    logic signed [TOTAL_PREC-1:0] t;
    logic [7:0]                   bri;

    logic                         fb_we;
    fb_addr_t                     fb_waddr;
    logic [7:0]                   fb_wdata;
    logic                         frame_done;
    logic                         busy;
    fb_addr_t                     pix_count;
    fb_addr_t                     hit_count;
    logic                         addr_err;

    modport master (
        output in_valid, fb_addr, last_tri, last_pix, hit, t, bri,
        input  fb_we, fb_waddr, fb_wdata, frame_done, busy, pix_count, hit_count, addr_err
    );

    modport slave (
        input  in_valid, fb_addr, last_tri, last_pix, hit, t, bri,
        output fb_we, fb_waddr, fb_wdata, frame_done, busy, pix_count, hit_count, addr_err
    );

endinterface

// File: rtl/hit_resolve_depth_select.sv
// depth_select: combinational nearest-hit merge of one beat into the running best.
//   in : have_hit, best_t, best_bri (running), hit, t, bri (beat)
//   out: nxt_have_hit, nxt_best_t, nxt_best_bri
// Only strictly positive t qualifies; ties keep the earlier (running) hit.
module depth_select #(
    parameter int unsigned W = render_pkg::TOTAL_PREC_DEF
) (
    input  logic                have_hit,
    input  logic signed [W-1:0] best_t,
    input  logic [7:0]          best_bri,
    input  logic                hit,
    input  logic signed [W-1:0] t,
    input  logic [7:0]          bri,
    output logic                nxt_have_hit,
    output logic signed [W-1:0] nxt_best_t,
    output logic [7:0]          nxt_best_bri
);

    logic qual;
    logic win;

    always_comb begin
        // sign bit clear and nonzero is t > 0 without any unsigned-literal pitfalls
        qual         = hit && !t[W-1] && (t != '0);
        win          = qual && (!have_hit || (t < best_t));
        nxt_have_hit = have_hit || qual;
        nxt_best_t   = win ? t : best_t;
        nxt_best_bri = win ? bri : best_bri;
    end

endmodule

// File: rtl/hit_resolve.sv
// hit_resolve: per-pixel nearest positive hit resolution with one framebuffer write per pixel.
//   clk, rst : clock and synchronous active-high reset
//   bus      : hit_resolve_if.slave (beat stream in, framebuffer write + frame stats out)
// Writes are registered: visible the cycle after the last_tri beat. Counters clear on the
// first beat of a frame (taken in IDLE); addr_err is sticky until reset.
module hit_resolve
    import render_pkg::*;
#(
    parameter int unsigned TOTAL_PREC = TOTAL_PREC_DEF,
    parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
    parameter logic [7:0]  BG_BRI     = BG_BRI_DEF
) (
    input logic          clk,
    input logic          rst,
    hit_resolve_if.slave bus
);

    if (FRAC_BITS >= TOTAL_PREC) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than TOTAL_PREC");
    end

    resolve_state_t               state_q;
    logic                         have_hit_q;
    logic signed [TOTAL_PREC-1:0] best_t_q;
    logic [7:0]                   best_bri_q;
    fb_addr_t                     grp_addr_q;
    logic                         grp_open_q;

    logic                         fb_we_q;
    fb_addr_t                     fb_waddr_q;
    logic [7:0]                   fb_wdata_q;
    logic                         frame_done_q;
    fb_addr_t                     pix_count_q;
    fb_addr_t                     hit_count_q;
    logic                         addr_err_q;

    logic                         nxt_have_hit;
    logic signed [TOTAL_PREC-1:0] nxt_best_t;
    logic [7:0]                   nxt_best_bri;
    fb_addr_t                     wr_addr;
    fb_addr_t                     pix_base;
    fb_addr_t                     hit_base;
    logic                         frame_end;

    depth_select #(
        .W (TOTAL_PREC)
    ) u_depth_select (
        .have_hit     (have_hit_q),
        .best_t       (best_t_q),
        .best_bri     (best_bri_q),
        .hit          (bus.hit),
        .t            (bus.t),
        .bri          (bus.bri),
        .nxt_have_hit (nxt_have_hit),
        .nxt_best_t   (nxt_best_t),
        .nxt_best_bri (nxt_best_bri)
    );

    always_comb begin
        // a single-beat group writes to its own address
        wr_addr   = grp_open_q ? grp_addr_q : bus.fb_addr;
        frame_end = bus.last_tri && bus.last_pix;
        // first beat of a frame restarts the statistics
        pix_base  = (state_q == IDLE) ? '0 : pix_count_q;
        hit_base  = (state_q == IDLE) ? '0 : hit_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            have_hit_q   <= 1'b0;
            best_t_q     <= '0;
            best_bri_q   <= '0;
            grp_addr_q   <= '0;
            grp_open_q   <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_waddr_q   <= '0;
            fb_wdata_q   <= '0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
            hit_count_q  <= '0;
            addr_err_q   <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.in_valid) begin
                if (grp_open_q && (bus.fb_addr != grp_addr_q)) begin
                    addr_err_q <= 1'b1;
                end
                if (bus.last_tri) begin
                    fb_we_q      <= 1'b1;
                    fb_waddr_q   <= wr_addr;
                    fb_wdata_q   <= nxt_have_hit ? nxt_best_bri : BG_BRI;
                    frame_done_q <= bus.last_pix;
                    pix_count_q  <= pix_base + 20'd1;
                    hit_count_q  <= hit_base + {19'd0, nxt_have_hit};
                    have_hit_q   <= 1'b0;
                    best_t_q     <= '0;
                    best_bri_q   <= '0;
                    grp_open_q   <= 1'b0;
                end else begin
                    have_hit_q  <= nxt_have_hit;
                    best_t_q    <= nxt_best_t;
                    best_bri_q  <= nxt_best_bri;
                    grp_open_q  <= 1'b1;
                    pix_count_q <= pix_base;
                    hit_count_q <= hit_base;
                    if (!grp_open_q) begin
                        grp_addr_q <= bus.fb_addr;
                    end
                end
                state_q <= frame_end ? IDLE : ACCUM;
            end
        end
    end

    assign bus.fb_we      = fb_we_q;
    assign bus.fb_waddr   = fb_waddr_q;
    assign bus.fb_wdata   = fb_wdata_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q == ACCUM);
    assign bus.pix_count  = pix_count_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_hit_resolve.sv
// Bench for hit_resolve: a fixed vector table, hand sequences for reset/gap/address corner
// cases, then random frames, all also checked against a group-queue reference model.
module tb_hit_resolve;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hit_resolve_if #(.TOTAL_PREC(27)) bus ();

    hit_resolve dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic signed [26:0] ONE = 27'sd4194304;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [19:0]        addr;
        logic               hit;
        logic signed [26:0] t;
        logic [7:0]         bri;
    } beat_t;

    // reference model state
    beat_t       grp[$];
    logic        m_busy = 1'b0;
    logic [19:0] m_pix = '0, m_hit = '0;
    logic        m_err = 1'b0, m_we = 1'b0, m_done = 1'b0;
    logic [19:0] m_waddr = '0;
    logic [7:0]  m_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [19:0] a, input logic lt,
                         input logic lp, input logic h, input logic signed [26:0] tt,
                         input logic [7:0] b);
        int    best;
        beat_t nb;
        if (r) begin
            grp.delete();
            m_busy = 0; m_pix = 0; m_hit = 0; m_err = 0;
            m_we = 0; m_waddr = 0; m_wdata = 0; m_done = 0;
        end else begin
            m_we = 0;
            m_done = 0;
            if (v) begin
                if (!m_busy) begin
                    m_pix = 0;
                    m_hit = 0;
                end
                if (grp.size() > 0 && a != grp[0].addr) m_err = 1;
                nb.addr = a; nb.hit = h; nb.t = tt; nb.bri = b;
                grp.push_back(nb);
                if (lt) begin
                    best = -1;
                    foreach (grp[i]) begin
                        if (grp[i].hit && grp[i].t > 0 && (best < 0 || grp[i].t < grp[best].t))
                            best = i;
                    end
                    m_we    = 1;
                    m_waddr = grp[0].addr;
                    m_wdata = (best >= 0) ? grp[best].bri : 8'd0;
                    m_pix   = m_pix + 20'd1;
                    if (best >= 0) m_hit = m_hit + 20'd1;
                    m_done  = lp;
                    grp.delete();
                end
                m_busy = !(lt && lp);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [19:0] a, input logic lt,
                        input logic lp, input logic h, input logic signed [26:0] tt,
                        input logic [7:0] b);
        @(negedge clk);
        rst = r;
        bus.in_valid = v; bus.fb_addr = a; bus.last_tri = lt; bus.last_pix = lp;
        bus.hit = h; bus.t = tt; bus.bri = b;
        @(posedge clk);
        #1;
        model(r, v, a, lt, lp, h, tt, b);
        chk("model_we",    32'(bus.fb_we),      32'(m_we));
        chk("model_waddr", 32'(bus.fb_waddr),   32'(m_waddr));
        chk("model_wdata", 32'(bus.fb_wdata),   32'(m_wdata));
        chk("model_done",  32'(bus.frame_done), 32'(m_done));
        chk("model_busy",  32'(bus.busy),       32'(m_busy));
        chk("model_pix",   32'(bus.pix_count),  32'(m_pix));
        chk("model_hit",   32'(bus.hit_count),  32'(m_hit));
        chk("model_err",   32'(bus.addr_err),   32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 27'sd0, 8'd0);
    endtask

    function automatic logic signed [26:0] pick_t();
        case ($urandom_range(0, 5))
            0:       pick_t = -27'($urandom_range(1, 8388608));
            1:       pick_t = 27'sd0;
            2:       pick_t = ONE;
            3:       pick_t = 27'sd8388608;
            4:       pick_t = 27'($urandom_range(1, 16));
            default: pick_t = 27'($urandom_range(1, 67108863));
        endcase
    endfunction

    typedef struct {
        logic               rst, valid;
        logic [19:0]        addr;
        logic               lt, lp, hit;
        logic signed [26:0] t;
        logic [7:0]         bri;
        logic               e_we;
        logic [19:0]        e_waddr;
        logic [7:0]         e_wdata;
        logic               e_done, e_busy;
        logic [19:0]        e_pix, e_hit;
        logic               e_err;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // rst valid addr lt lp hit t bri | we waddr wdata done busy pix hit err
        vecs[0]  = '{1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 27'sd0, 8'd0,
                     1'b0, 20'd0, 8'd0, 1'b0, 1'b0, 20'd0, 20'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 20'd5, 1'b0, 1'b0, 1'b1, 27'sd8388608, 8'd40,
                     1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 20'd0, 20'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 20'd5, 1'b0, 1'b0, 1'b1, ONE, 8'd90,
                     1'b0, 20'd0, 8'd0, 1'b0, 1'b1, 20'd0, 20'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 20'd5, 1'b1, 1'b0, 1'b1, ONE, 8'd10,
                     1'b1, 20'd5, 8'd90, 1'b0, 1'b1, 20'd1, 20'd1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 20'd7, 1'b0, 1'b0, 1'b0, 27'sd0, 8'd33,
                     1'b0, 20'd5, 8'd90, 1'b0, 1'b1, 20'd1, 20'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 20'd7, 1'b0, 1'b0, 1'b1, -ONE, 8'd44,
                     1'b0, 20'd5, 8'd90, 1'b0, 1'b1, 20'd1, 20'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 20'd7, 1'b1, 1'b1, 1'b1, 27'sd0, 8'd66,
                     1'b1, 20'd7, 8'd0, 1'b1, 1'b0, 20'd2, 20'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 20'd0, 1'b1, 1'b0, 1'b1, ONE, 8'd1,
                     1'b1, 20'd0, 8'd1, 1'b0, 1'b1, 20'd1, 20'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 20'd1, 1'b1, 1'b0, 1'b1, ONE, 8'd2,
                     1'b1, 20'd1, 8'd2, 1'b0, 1'b1, 20'd2, 20'd2, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 20'd2, 1'b1, 1'b0, 1'b1, ONE, 8'd3,
                     1'b1, 20'd2, 8'd3, 1'b0, 1'b1, 20'd3, 20'd3, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 20'd3, 1'b1, 1'b1, 1'b1, ONE, 8'd4,
                     1'b1, 20'd3, 8'd4, 1'b1, 1'b0, 20'd4, 20'd4, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 27'sd0, 8'd0,
                     1'b0, 20'd3, 8'd4, 1'b0, 1'b0, 20'd4, 20'd4, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 20'd8, 1'b1, 1'b1, 1'b1, ONE, 8'd200,
                     1'b0, 20'd3, 8'd4, 1'b0, 1'b0, 20'd4, 20'd4, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 20'd9, 1'b0, 1'b1, 1'b1, ONE, 8'd99,
                     1'b0, 20'd3, 8'd4, 1'b0, 1'b1, 20'd0, 20'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 20'd9, 1'b1, 1'b0, 1'b1, 27'sd8388608, 8'd50,
                     1'b1, 20'd9, 8'd99, 1'b0, 1'b1, 20'd1, 20'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 20'd12, 1'b1, 1'b1, 1'b0, ONE, 8'd70,
                     1'b1, 20'd12, 8'd0, 1'b1, 1'b0, 20'd2, 20'd1, 1'b0};

        bus.in_valid = 0; bus.fb_addr = '0; bus.last_tri = 0; bus.last_pix = 0;
        bus.hit = 0; bus.t = '0; bus.bri = '0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].addr, vecs[i].lt, vecs[i].lp,
                 vecs[i].hit, vecs[i].t, vecs[i].bri);
            chk($sformatf("vec%0d_we", i),    32'(bus.fb_we),      32'(vecs[i].e_we));
            chk($sformatf("vec%0d_waddr", i), 32'(bus.fb_waddr),   32'(vecs[i].e_waddr));
            chk($sformatf("vec%0d_wdata", i), 32'(bus.fb_wdata),   32'(vecs[i].e_wdata));
            chk($sformatf("vec%0d_done", i),  32'(bus.frame_done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_busy", i),  32'(bus.busy),       32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_pix", i),   32'(bus.pix_count),  32'(vecs[i].e_pix));
            chk($sformatf("vec%0d_hit", i),   32'(bus.hit_count),  32'(vecs[i].e_hit));
            chk($sformatf("vec%0d_err", i),   32'(bus.addr_err),   32'(vecs[i].e_err));
        end

        // address change inside a group: sticky error, write goes to the first address
        step(1'b0, 1'b1, 20'd10, 1'b0, 1'b0, 1'b1, ONE, 8'd5);
        step(1'b0, 1'b1, 20'd11, 1'b1, 1'b0, 1'b0, ONE, 8'd6);
        chk("aerr_flag",  32'(bus.addr_err), 32'd1);
        chk("aerr_waddr", 32'(bus.fb_waddr), 32'd10);
        chk("aerr_wdata", 32'(bus.fb_wdata), 32'd5);
        idle();
        idle();
        chk("aerr_sticky", 32'(bus.addr_err), 32'd1);

        // reset mid-group discards it; a fresh pixel follows
        step(1'b0, 1'b1, 20'd20, 1'b0, 1'b0, 1'b1, 27'sd8388608, 8'd9);
        step(1'b0, 1'b1, 20'd20, 1'b0, 1'b0, 1'b1, ONE, 8'd8);
        step(1'b1, 1'b0, 20'd0, 1'b0, 1'b0, 1'b0, 27'sd0, 8'd0);
        chk("rst_no_we", 32'(bus.fb_we), 32'd0);
        chk("rst_err",   32'(bus.addr_err), 32'd0);
        step(1'b0, 1'b1, 20'd21, 1'b1, 1'b0, 1'b1, ONE, 8'd55);
        chk("rst_fresh_we",    32'(bus.fb_we),     32'd1);
        chk("rst_fresh_waddr", 32'(bus.fb_waddr),  32'd21);
        chk("rst_fresh_wdata", 32'(bus.fb_wdata),  32'd55);
        chk("rst_fresh_pix",   32'(bus.pix_count), 32'd1);

        // reset wins over a last_tri beat in the same cycle
        step(1'b0, 1'b1, 20'd25, 1'b0, 1'b0, 1'b1, ONE, 8'd3);
        step(1'b1, 1'b1, 20'd25, 1'b1, 1'b1, 1'b1, ONE, 8'd4);
        chk("rst_lt_we", 32'(bus.fb_we), 32'd0);
        idle();
        chk("rst_lt_we_next", 32'(bus.fb_we), 32'd0);

        // gapped two-beat group
        step(1'b0, 1'b1, 20'd30, 1'b0, 1'b0, 1'b1, 27'sd6291456, 8'd12);
        idle();
        step(1'b0, 1'b1, 20'd30, 1'b1, 1'b1, 1'b1, 27'sd2097152, 8'd77);
        chk("gap_we",    32'(bus.fb_we),      32'd1);
        chk("gap_waddr", 32'(bus.fb_waddr),   32'd30);
        chk("gap_wdata", 32'(bus.fb_wdata),   32'd77);
        chk("gap_done",  32'(bus.frame_done), 32'd1);
        idle();
        chk("gap_we_once", 32'(bus.fb_we), 32'd0);

        // random frames against the model
        for (int f = 0; f < 80; f++) begin
            int npix;
            npix = $urandom_range(1, 6);
            for (int p = 0; p < npix; p++) begin
                int          nb;
                logic [19:0] pa;
                pa = 20'($urandom_range(0, 1048575));
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    logic lt, lp, r;
                    logic [19:0] a;
                    while ($urandom_range(0, 3) == 0)
                        step(1'b0, 1'b0, 20'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), pick_t(), 8'($urandom));
                    lt = (b == nb - 1);
                    lp = lt ? (p == npix - 1) : ($urandom_range(0, 7) == 0);
                    a  = ($urandom_range(0, 39) == 0) ? pa + 20'd1 : pa;
                    r  = ($urandom_range(0, 299) == 0);
                    step(r, 1'b1, a, lt, lp, 1'($urandom_range(0, 3) != 0), pick_t(),
                         8'($urandom));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_resolve.md
# hit_resolve

Consumes the per-triangle result stream of the render pipeline (`ofb_addr`, `olast_tri`, `olast_pix`, `hit`, `t`, `bri`) and resolves, per pixel, the nearest positive-distance hit. One framebuffer write per pixel: the winning brightness, or a background value if nothing hit. Sits between the render pipeline output and the framebuffer write port. Also tracks frame completion and per-frame statistics.

## Interface
- `TOTAL_PREC`, 27, total bits of signed fixed-point `t`
- `FRAC_BITS`, 22, fractional bits of `t` (1.0 = 4194304)
- `BG_BRI`, 8'd0, brightness written for pixels with no valid hit

- `clk` in 1 — sole clock
- `rst` in 1 — synchronous, active-high reset
- `in_valid` in 1 — beat qualifier for all inputs below
- `fb_addr` in 20 — pixel address of this beat
- `last_tri` in 1 — final triangle beat for this pixel
- `last_pix` in 1 — final pixel of the frame; only meaningful with `last_tri`
- `hit` in 1 — ray hit this triangle
- `t` in TOTAL_PREC signed — hit distance
- `bri` in 8 — brightness for this hit
- `fb_we` out 1 — framebuffer write strobe
- `fb_waddr` out 20 — write address
- `fb_wdata` out 8 — write data
- `frame_done` out 1 — one-cycle pulse with the final write of a frame
- `busy` out 1 — high while a frame is in progress
- `pix_count` out 20 — pixels written this frame
- `hit_count` out 20 — pixels written with a real hit this frame
- `addr_err` out 1 — sticky; `fb_addr` changed within a pixel group

## Operation
- States: IDLE, ACCUM. IDLE→ACCUM on any `in_valid` beat that is not itself `last_tri && last_pix`. ACCUM→IDLE on a beat with `last_tri && last_pix`. `busy` = state is ACCUM.
- The first beat of a frame, taken in IDLE, clears `pix_count` and `hit_count`. `addr_err` is not cleared.
- Accumulator state: `best_t`, `best_bri`, `have_hit`, `grp_addr`.
- A beat qualifies when `in_valid && hit && t > 0`. Signed compare; `t <= 0` counts as a miss.
- A qualifying beat wins when `!have_hit || t < best_t`. The comparison is strict, so on ties the earlier triangle is kept.
- The first beat of a pixel group latches `grp_addr`.
- On a later beat of the same group, if `fb_addr != grp_addr`, set `addr_err`. The write still uses `grp_addr`.
- On a `last_tri` beat, the current beat participates in resolution. Then:
  - Issue the write: address `grp_addr` (or `fb_addr` for a single-beat group), data `best_bri` if there was any hit, else `BG_BRI`.
  - Increment `pix_count`, and `hit_count` if there was a hit.
  - Clear the accumulator for the next pixel.
- `last_pix` without `last_tri` is ignored.
- Beats with `in_valid = 0` change nothing.

## Timing
- Write registered: `fb_we`, `fb_waddr`, `fb_wdata` are valid the cycle after the `last_tri` beat, with `fb_we` high for exactly one cycle.
- `frame_done` is asserted in the same cycle as the write for a `last_tri && last_pix` beat.
- `pix_count` and `hit_count` update in the same cycle the write is visible.
- One beat per cycle is sustained with no backpressure. Back-to-back single-beat pixels give back-to-back writes.
- Reset values: all outputs 0, state IDLE, accumulator cleared.
- Reset mid-pixel discards the partial group and issues no write. Reset in the same cycle as a `last_tri` beat wins, so no write follows.
- Counters wrap modulo 2^20.

## Structure
- Shared `render_pkg` holds:
  - `TOTAL_PREC`, `FRAC_BITS` defaults
  - `BG_BRI`
  - state enum `resolve_state_t` {IDLE, ACCUM}
  - 20-bit `fb_addr_t` typedef
- One natural sub-module, `depth_select`: combinational. Inputs `have_hit`, `best_t`, `best_bri`, and the beat's `hit`, `t`, `bri`. Outputs are the next `best_*` and `have_hit`. It is reused for the `last_tri` merge path.

## Test plan
- Single pixel at addr 5, three beats:
  - t = 2.0 (8388608) bri 40
  - t = 1.0 (4194304) bri 90
  - t = 1.0 bri 10, with `last_tri`
  - → one write, addr 5, data 90 (tie keeps earlier), the cycle after beat 3.
- Pixel at addr 7, beats: hit = 0; t = −4194304 with `hit`; t = 0 with `hit`, `last_tri`. → write addr 7, data `BG_BRI` = 0; `hit_count` unchanged.
- Four single-beat pixels, addr 0..3, each with `last_tri`, the last also with `last_pix`, all hits bri 1..4. → four consecutive writes with data 1..4; `frame_done` with the addr 3 write; `pix_count` = 4, `hit_count` = 4; `busy` low afterwards.
- Group starting at addr 10, second beat at addr 11 with `last_tri`. → `addr_err` set and stays set; write goes to addr 10.
- Assert `rst` for one cycle between the 2nd and 3rd beat of a group at addr 20, then feed a fresh single-beat pixel at addr 21 (t = 1.0, bri 55). → no write to 20; write addr 21 data 55; `pix_count` = 1.
- `in_valid` toggling 1/0 across a 2-beat hit group at addr 30 (bri 77 nearest). → identical result to an ungapped stream: one write, addr 30, data 77.
